// File: rtl/uart_frame_scheduler.sv
// rtl/uart_frame_scheduler.sv - receives an image frame over UART, forwards pixels, buffers face records, sends them back
//
// Ports:
//   clock, reset                    clock and asynchronous active-low reset
//   rx_data, rx_valid               bytes from the UART receiver
//   cts / rts                       host ready to receive / this block ready to receive
//   pix_data, pix_valid, frame_start  pixel stream to the face detector
//   det_face_valid, det_x1..det_y2  face boxes reported by the detector
//   det_done                        detector finished the frame
//   tx_data, tx_send, tx_sent       byte handshake with the UART transmitter
//   busy                            not IDLE
//   face_overflow, rx_overrun       sticky error flags, cleared by the first byte of a frame
module uart_frame_scheduler #(
    parameter logic [15:0] PIXELS    = 16'd4096,
    parameter int          MAX_FACES = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       cts,
    output logic       rts,
    output logic [7:0] pix_data,
    output logic       pix_valid,
    output logic       frame_start,
    input  logic       det_face_valid,
    input  logic [7:0] det_x1,
    input  logic [7:0] det_y1,
    input  logic [7:0] det_x2,
    input  logic [7:0] det_y2,
    input  logic       det_done,
    output logic [7:0] tx_data,
    output logic       tx_send,
    input  logic       tx_sent,
    output logic       busy,
    output logic       face_overflow,
    output logic       rx_overrun
);

    typedef enum logic [2:0] {IDLE, RECV, PROC, TX_CNT, TX_REC} state_t;

    // Buffer is rounded up to a power of two so the record index is a plain bit slice.
    localparam int         IDX_W   = (MAX_FACES > 1) ? $clog2(MAX_FACES) : 1;
    localparam logic [7:0] MAX_CNT = 8'(MAX_FACES);

    state_t      state_q, state_d;
    logic [15:0] pix_cnt;
    logic [7:0]  rec_count;
    logic [7:0]  rec_idx;
    logic [1:0]  byte_idx;
    logic [31:0] face_buf [0:(1 << IDX_W) - 1];
    logic [31:0] rd_rec;
    logic [7:0]  cur_byte;
    logic        rx_accept;
    logic        face_wr;
    logic        byte_done;
    logic        in_tx;

    assign rx_accept = rx_valid && (state_q == IDLE || state_q == RECV);
    assign face_wr   = (state_q == PROC) && det_face_valid && (rec_count != MAX_CNT);
    assign byte_done = tx_send && tx_sent;
    assign in_tx     = (state_q == TX_CNT) || (state_q == TX_REC);
    assign busy      = (state_q != IDLE);
    assign rts       = (state_q == IDLE) || (state_q == RECV);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rx_valid) state_d = (PIXELS == 16'd1) ? PROC : RECV;
            RECV:    if (rx_valid && pix_cnt == PIXELS - 16'd1) state_d = PROC;
            PROC:    if (det_done) state_d = TX_CNT;
            TX_CNT:  if (byte_done) state_d = (rec_count != 8'd0) ? TX_REC : IDLE;
            TX_REC:  if (byte_done && byte_idx == 2'd3 && rec_idx + 8'd1 == rec_count)
                         state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Byte to present: the count first, then x1,y1,x2,y2 of each record (x1 in the top byte).
    always_comb begin
        rd_rec   = face_buf[rec_idx[IDX_W-1:0]];
        cur_byte = rd_rec[31:24];
        case (byte_idx)
            2'd0: cur_byte = rd_rec[31:24];
            2'd1: cur_byte = rd_rec[23:16];
            2'd2: cur_byte = rd_rec[15:8];
            2'd3: cur_byte = rd_rec[7:0];
            default: cur_byte = rd_rec[31:24];
        endcase
        if (state_q == TX_CNT) cur_byte = rec_count;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pix_valid     <= 1'b0;
            pix_data      <= 8'd0;
            frame_start   <= 1'b0;
            pix_cnt       <= 16'd0;
            rec_count     <= 8'd0;
            rec_idx       <= 8'd0;
            byte_idx      <= 2'd0;
            face_overflow <= 1'b0;
            rx_overrun    <= 1'b0;
            tx_send       <= 1'b0;
            tx_data       <= 8'd0;
        end else begin
            pix_valid   <= rx_accept;
            frame_start <= rx_accept && (state_q == IDLE);
            if (rx_accept) pix_data <= rx_data;

            if (state_q == IDLE && rx_valid) begin
                pix_cnt       <= 16'd1;
                rec_count     <= 8'd0;
                rec_idx       <= 8'd0;
                byte_idx      <= 2'd0;
                face_overflow <= 1'b0;
                rx_overrun    <= 1'b0;
            end else if (state_q == RECV && rx_valid) begin
                pix_cnt <= pix_cnt + 16'd1;
            end

            if (rx_valid && !rx_accept) rx_overrun <= 1'b1;

            if (state_q == PROC && det_face_valid) begin
                if (face_wr) rec_count <= rec_count + 8'd1;
                else         face_overflow <= 1'b1;
            end

            // tx_send is registered, so after tx_sent it is low for exactly one cycle
            // before the next byte can be requested.
            if (in_tx) begin
                if (!tx_send) begin
                    if (cts) begin
                        tx_send <= 1'b1;
                        tx_data <= cur_byte;
                    end
                end else if (tx_sent) begin
                    tx_send <= 1'b0;
                    if (state_q == TX_REC) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) rec_idx <= rec_idx + 8'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (face_wr) face_buf[rec_count[IDX_W-1:0]] <= {det_x1, det_y1, det_x2, det_y2};
    end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// tb/tb_uart_frame_scheduler.sv - directed self-checking bench for uart_frame_scheduler
module tb_uart_frame_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       cts;
    logic       rts;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       frame_start;
    logic       det_face_valid;
    logic [7:0] det_x1, det_y1, det_x2, det_y2;
    logic       det_done;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_sent;
    logic       busy;
    logic       face_overflow;
    logic       rx_overrun;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    uart_frame_scheduler #(.PIXELS(16'd4), .MAX_FACES(2)) dut (
        .clock(clock), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .cts(cts), .rts(rts),
        .pix_data(pix_data), .pix_valid(pix_valid), .frame_start(frame_start),
        .det_face_valid(det_face_valid),
        .det_x1(det_x1), .det_y1(det_y1), .det_x2(det_x2), .det_y2(det_y2),
        .det_done(det_done),
        .tx_data(tx_data), .tx_send(tx_send), .tx_sent(tx_sent),
        .busy(busy), .face_overflow(face_overflow), .rx_overrun(rx_overrun)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // All tasks start and end at a falling edge.
    task automatic send_pix(input logic [7:0] b, input logic first);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clock);
        rx_valid = 1'b0;
        check("pix_valid", pix_valid, 1);
        check("pix_data", pix_data, b);
        check("frame_start", frame_start, first);
    endtask

    task automatic det(input logic fv, input logic [7:0] x1, input logic [7:0] y1,
                       input logic [7:0] x2, input logic [7:0] y2, input logic done);
        det_face_valid = fv;
        det_x1 = x1; det_y1 = y1; det_x2 = x2; det_y2 = y2;
        det_done = done;
        @(negedge clock);
        det_face_valid = 1'b0;
        det_done       = 1'b0;
    endtask

    task automatic wait_send(input string tag);
        int n = 0;
        while (!tx_send && n < 300) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_send"}, tx_send, 1);
    endtask

    task automatic get_byte(input logic [7:0] exp, input string tag);
        wait_send(tag);
        check(tag, tx_data, exp);
        @(negedge clock);
        tx_sent = 1'b1;
        @(negedge clock);
        tx_sent = 1'b0;
        check({tag, "_drop"}, tx_send, 0);
    endtask

    initial begin
        logic seen;
        reset = 1'b0; rx_data = 8'd0; rx_valid = 1'b0; cts = 1'b1;
        det_face_valid = 1'b0; det_x1 = 0; det_y1 = 0; det_x2 = 0; det_y2 = 0;
        det_done = 1'b0; tx_sent = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_rts", rts, 1);
        check("rst_busy", busy, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_tx_send", tx_send, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_flags", {face_overflow, rx_overrun}, 0);
        reset = 1'b1;
        @(negedge clock);

        // Frame A: four pixels, one face, full response.
        send_pix(8'h10, 1'b1);
        send_pix(8'h11, 1'b0);
        send_pix(8'h12, 1'b0);
        check("a_rts_recv", rts, 1);
        send_pix(8'h13, 1'b0);
        check("a_rts_proc", rts, 0);
        check("a_busy", busy, 1);
        @(negedge clock);
        check("a_pix_idle", pix_valid, 0);
        det(1'b1, 8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
        det(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
        get_byte(8'h01, "a_cnt");
        get_byte(8'h01, "a_x1");
        get_byte(8'h02, "a_y1");
        get_byte(8'h03, "a_x2");
        get_byte(8'h04, "a_y2");
        check("a_end_busy", busy, 0);
        check("a_end_rts", rts, 1);

        // Frame B: detector events outside PROC are ignored, no faces.
        det(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
        check("b_idle_done", busy, 0);
        send_pix(8'h20, 1'b1);
        det(1'b1, 8'h55, 8'h55, 8'h55, 8'h55, 1'b0);
        send_pix(8'h21, 1'b0);
        send_pix(8'h22, 1'b0);
        send_pix(8'h23, 1'b0);
        det(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
        get_byte(8'h00, "b_cnt");
        check("b_end_busy", busy, 0);

        // Frame C: overrun during PROC, three faces into a two-deep buffer.
        send_pix(8'h30, 1'b1);
        send_pix(8'h31, 1'b0);
        send_pix(8'h32, 1'b0);
        send_pix(8'h33, 1'b0);
        rx_data = 8'h99; rx_valid = 1'b1;
        @(negedge clock);
        rx_valid = 1'b0;
        check("c_ovr_pix", pix_valid, 0);
        check("c_rx_overrun", rx_overrun, 1);
        det(1'b1, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 1'b0);
        det(1'b1, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 1'b0);
        check("c_no_ovf_yet", face_overflow, 0);
        det(1'b1, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 1'b0);
        check("c_face_ovf", face_overflow, 1);
        det(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
        get_byte(8'h02, "c_cnt");
        get_byte(8'hA1, "c_a1");
        get_byte(8'hA2, "c_a2");
        get_byte(8'hA3, "c_a3");
        get_byte(8'hA4, "c_a4");
        get_byte(8'hB1, "c_b1");
        get_byte(8'hB2, "c_b2");
        get_byte(8'hB3, "c_b3");
        get_byte(8'hB4, "c_b4");
        check("c_end_busy", busy, 0);
        check("c_ovf_sticky", face_overflow, 1);

        // Frame D: flags clear on first byte, face+done together, cts flow control.
        send_pix(8'h40, 1'b1);
        check("d_ovf_clr", face_overflow, 0);
        check("d_overrun_clr", rx_overrun, 0);
        send_pix(8'h41, 1'b0);
        send_pix(8'h42, 1'b0);
        send_pix(8'h43, 1'b0);
        cts = 1'b0;
        det(1'b1, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tx_sent = (i == 50);
            @(negedge clock);
            seen = seen | tx_send;
        end
        tx_sent = 1'b0;
        check("d_cts_stall", seen, 0);
        cts = 1'b1;
        wait_send("d_cnt");
        check("d_cnt", tx_data, 8'h01);
        cts = 1'b0;
        repeat (5) @(negedge clock);
        check("d_hold_send", tx_send, 1);
        check("d_hold_data", tx_data, 8'h01);
        tx_sent = 1'b1;
        @(negedge clock);
        tx_sent = 1'b0;
        check("d_cnt_drop", tx_send, 0);
        cts = 1'b1;
        get_byte(8'hD1, "d_x1");
        get_byte(8'hD2, "d_y1");
        get_byte(8'hD3, "d_x2");
        get_byte(8'hD4, "d_y2");
        check("d_end_busy", busy, 0);

        // Frame E: reset mid-RECV abandons the frame; next frame restarts at pixel 0.
        send_pix(8'h50, 1'b1);
        send_pix(8'h51, 1'b0);
        reset = 1'b0;
        #1;
        check("e_rst_rts", rts, 1);
        check("e_rst_busy", busy, 0);
        check("e_rst_pix", pix_valid, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        send_pix(8'h60, 1'b1);
        send_pix(8'h61, 1'b0);
        send_pix(8'h62, 1'b0);
        check("e_rts_recv", rts, 1);
        send_pix(8'h63, 1'b0);
        check("e_rts_proc", rts, 0);
        det(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
        get_byte(8'h00, "e_cnt");
        check("e_end_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
